sort4_cmp_ctrl: RTL and testbench
=================================

Name: sort4_cmp_ctrl

Overview:
- Sequencer that sorts four WIDTH-bit values by time-sharing one external combinational magnitude comparator (A/B in, AgtB/AltB/AeqB out).
- Runs a fixed 6-compare bubble-sort schedule and swaps register contents based on the comparator result.
- Sits between a requester (start/din, done/dout) and the existing 4-bit comparator instance.
- Also reports the swap count and a sticky comparator-consistency error.

Parameters:
- WIDTH, 4, bit width of each element and of the comparator operands.
- DESCEND, 0, 0 = ascending order (element 0 smallest), 1 = descending.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- din  input  4*WIDTH  packed elements; element i = din[i*WIDTH +: WIDTH].
- busy  output  1  high from the cycle after start acceptance through the DONE cycle.
- done  output  1  one-cycle pulse, sorted result valid.
- dout  output  4*WIDTH  sorted elements, same packing as din.
- swaps  output  3  number of swaps performed in the last sort (0..6).
- cmp_a  output  WIDTH  operand A to comparator.
- cmp_b  output  WIDTH  operand B to comparator.
- cmp_gt  input  1  comparator AgtB.
- cmp_lt  input  1  comparator AltB.
- cmp_eq  input  1  comparator AeqB.
- cmp_err  output  1  sticky; set when gt/lt/eq are not exactly one-hot during a compare cycle.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; busy, done, cmp_err = 0; dout, swaps, cmp_a, cmp_b = 0; step counter = 0. Reset mid-sort aborts at that edge with no partial result kept.
- States: IDLE, CMP, DONE.
- IDLE:
  - cmp_a = cmp_b = 0.
  - start=1 at an edge: load element regs from din, clear swaps, step=0, go to CMP.
  - cmp_err is not cleared by start; only reset clears it.
- CMP: one compare per cycle. Step pair schedule for steps 0..5: (0,1), (1,2), (2,3), (0,1), (1,2), (0,1).
  - cmp_a = reg[lo] and cmp_b = reg[hi], driven combinationally from the state regs.
  - Comparator is combinational; results are sampled at the same edge.
  - Swap condition: DESCEND=0 → swap when cmp_gt=1; DESCEND=1 → swap when cmp_lt=1. Equal values never swap, so the sort is stable.
  - On a swap, exchange reg[lo] and reg[hi] and increment swaps.
  - If {cmp_gt, cmp_lt, cmp_eq} is not one-hot at the edge, set cmp_err. The swap decision still follows the rule above.
  - After step 5, go to DONE.
- DONE:
  - done=1 for exactly one cycle; dout is updated from the element regs at the edge entering DONE.
  - Next edge returns to IDLE. A start in DONE is ignored.
- Latency: start sampled at edge E0; CMP steps occupy the cycles after E0..E5; done is high in the cycle after E6. Total 7 cycles, fixed and independent of data.
- busy=1 in CMP and DONE, 0 in IDLE.
- start while busy: ignored, no queuing.
- dout and swaps hold their last values until the next sort's DONE entry; they do not change during CMP.
- Back-to-back: start held high in the IDLE cycle after DONE begins a new sort, giving a throughput of one sort per 8 cycles.
- din is only sampled at acceptance; changes afterwards have no effect.

Test Plan:
- Ascending, din elements [12,3,10,5] → done 7 cycles after start; dout [3,5,10,12]; swaps=4; cmp_a/cmp_b sequence (12,3), (12,10), (12,5), (3,10), (10,5), (3,5).
- Pre-sorted [0,5,10,15] → dout unchanged; swaps=0.
- Reverse [15,10,5,0] → dout [0,5,10,15]; swaps=6.
- Duplicates [12,12,0,12] → dout [0,12,12,12]; swaps=2; cmp_err stays 0.
- Protocol checks:
  - start pulsed during step 2 → ignored, single done pulse.
  - rst_n=0 during step 3 → next edge busy=0, dout=0, swaps=0, no done.
  - Second start on the cycle after DONE → correct second result 8 cycles later.
- DESCEND=1 with [12,3,10,5] → dout [12,10,5,3]. A faulty comparator model driving gt=lt=1 on step 1 → cmp_err=1 from the next edge, held until reset.

Source files
------------

// File: rtl/sort4_cmp_ctrl.sv
// sort4_cmp_ctrl: sorts four WIDTH-bit elements with a fixed 6-step bubble
// schedule, sharing one external combinational magnitude comparator.
// The step sequence takes 7 cycles from start to done, whatever the data.
module sort4_cmp_ctrl #(
  parameter int WIDTH   = 4,
  parameter bit DESCEND = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [4*WIDTH-1:0] din,
  output logic               busy,
  output logic               done,
  output logic [4*WIDTH-1:0] dout,
  output logic [2:0]         swaps,
  output logic [WIDTH-1:0]   cmp_a,
  output logic [WIDTH-1:0]   cmp_b,
  input  logic               cmp_gt,
  input  logic               cmp_lt,
  input  logic               cmp_eq,
  output logic               cmp_err
);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t                  state, nextState;
  logic [3:0][WIDTH-1:0]   elem, elemNxt;
  logic [2:0]              step, swapCnt;
  logic [1:0]              lo, hi;
  logic                    swapNow, oneHot;

  // Pair schedule: (0,1) (1,2) (2,3) (0,1) (1,2) (0,1); hi is always lo+1
  always_comb begin
    lo = 2'd0;
    case (step)
      3'd1, 3'd4: lo = 2'd1;
      3'd2:       lo = 2'd2;
      default:    lo = 2'd0;
    endcase
    hi = lo + 2'd1;
  end

  // Swap decision and comparator sanity; equal never swaps so order is stable
  always_comb begin
    swapNow = DESCEND ? cmp_lt : cmp_gt;
    case ({cmp_gt, cmp_lt, cmp_eq})
      3'b100, 3'b010, 3'b001: oneHot = 1'b1;
      default:                oneHot = 1'b0;
    endcase
  end

  // Element registers after this cycle's conditional exchange
  always_comb begin
    elemNxt = elem;
    if (state == CMP && swapNow) begin
      elemNxt[lo] = elem[hi];
      elemNxt[hi] = elem[lo];
    end
  end

  // Comparator operands only live during compare cycles
  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    if (state == CMP) begin
      cmp_a = elem[lo];
      cmp_b = elem[hi];
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Next-state: accept in IDLE, six compares, one done cycle
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = CMP;
      CMP:     if (step == 3'd5) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Datapath: load, exchange, count, publish result on entry to DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      elem    <= '0;
      step    <= '0;
      swapCnt <= '0;
      dout    <= '0;
      swaps   <= '0;
      cmp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          elem    <= din;
          step    <= '0;
          swapCnt <= '0;
        end
        CMP: begin
          elem    <= elemNxt;
          swapCnt <= swapCnt + {2'b00, swapNow};
          step    <= step + 3'd1;
          if (!oneHot) cmp_err <= 1'b1;
          if (step == 3'd5) begin
            dout  <= elemNxt;
            swaps <= swapCnt + {2'b00, swapNow};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort4_cmp_ctrl.sv
// Directed bench for sort4_cmp_ctrl: an ascending and a descending instance
// share the request stimulus, each with its own behavioural comparator.
module tb_sort4_cmp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] din;
  logic        busy0, done0, err0, gt0, lt0, eq0;
  logic        busy1, done1, err1, gt1, lt1, eq1;
  logic [15:0] dout0, dout1;
  logic [2:0]  swaps0, swaps1;
  logic [3:0]  a0, b0, a1, b1;
  logic        fault1;

  int passCnt = 0;
  int totalCnt = 0;

  logic [7:0] obsSeq [6];
  logic       errSeq [6];

  always #5 clk = ~clk;

  sort4_cmp_ctrl #(.WIDTH(4), .DESCEND(1'b0)) dutAsc (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .busy(busy0),
    .done(done0), .dout(dout0), .swaps(swaps0), .cmp_a(a0), .cmp_b(b0),
    .cmp_gt(gt0), .cmp_lt(lt0), .cmp_eq(eq0), .cmp_err(err0));

  sort4_cmp_ctrl #(.WIDTH(4), .DESCEND(1'b1)) dutDesc (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .busy(busy1),
    .done(done1), .dout(dout1), .swaps(swaps1), .cmp_a(a1), .cmp_b(b1),
    .cmp_gt(gt1), .cmp_lt(lt1), .cmp_eq(eq1), .cmp_err(err1));

  // Ideal comparator for the ascending instance
  always_comb begin
    gt0 = (a0 > b0);
    lt0 = (a0 < b0);
    eq0 = (a0 == b0);
  end

  // Comparator for the descending instance, with an injectable gt=lt=1 fault
  always_comb begin
    gt1 = fault1 ? 1'b1 : (a1 > b1);
    lt1 = fault1 ? 1'b1 : (a1 < b1);
    eq1 = fault1 ? 1'b0 : (a1 == b1);
  end

  function automatic logic [15:0] p4(input int e0, input int e1, input int e2, input int e3);
    logic [3:0] v0, v1, v2, v3;
    v0 = e0[3:0]; v1 = e1[3:0]; v2 = e2[3:0]; v3 = e3[3:0];
    return {v3, v2, v1, v0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One full sort from an IDLE cycle; ends in the IDLE cycle after DONE
  task automatic runSort(input logic [15:0] d, input logic [15:0] expD, input logic [2:0] expS,
                         input int pulseAt, input int faultAt, input bit preStart,
                         input logic [15:0] nextD, input string nm);
    start = 1'b1; din = d;
    @(posedge clk); #1;
    start = 1'b0; din = ~d;
    for (int k = 0; k < 6; k++) begin
      obsSeq[k] = {a0, b0};
      errSeq[k] = err1;
      chk({nm, " busy/done in CMP"}, {30'd0, busy0, done0}, 32'd2);
      start  = (k == pulseAt);
      fault1 = (k == faultAt);
      @(posedge clk); #1;
    end
    start = 1'b0; fault1 = 1'b0;
    chk({nm, " done"},  {30'd0, busy0, done0}, 32'd3);
    chk({nm, " dout"},  {16'd0, dout0}, {16'd0, expD});
    chk({nm, " swaps"}, {29'd0, swaps0}, {29'd0, expS});
    if (preStart) begin start = 1'b1; din = nextD; end
    @(posedge clk); #1;
    chk({nm, " idle after done"}, {30'd0, busy0, done0}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] d;
    logic [15:0] expD;
    logic [2:0]  expS;
  } vec_t;

  vec_t vecs [6];
  bit   sawDone;

  initial begin
    vecs[0] = '{p4(12, 3, 10, 5),  p4(3, 5, 10, 12),  3'd4};
    vecs[1] = '{p4(0, 5, 10, 15),  p4(0, 5, 10, 15),  3'd0};
    vecs[2] = '{p4(15, 10, 5, 0),  p4(0, 5, 10, 15),  3'd6};
    vecs[3] = '{p4(12, 12, 0, 12), p4(0, 12, 12, 12), 3'd2};
    vecs[4] = '{p4(1, 0, 3, 2),    p4(0, 1, 2, 3),    3'd2};
    vecs[5] = '{p4(7, 7, 7, 7),    p4(7, 7, 7, 7),    3'd0};

    rst_n = 1'b0; start = 1'b0; din = '0; fault1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy/done", {30'd0, busy0, done0}, 32'd0);
    chk("reset dout",      {16'd0, dout0}, 32'd0);
    chk("reset swaps",     {29'd0, swaps0}, 32'd0);
    chk("reset cmp a/b",   {24'd0, a0, b0}, 32'd0);
    chk("reset cmp_err",   {30'd0, err0, err1}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: consecutive calls also exercise back-to-back starts
    for (int i = 0; i < 6; i++) begin
      runSort(vecs[i].d, vecs[i].expD, vecs[i].expS, -1, -1, 1'b0, '0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d cmp_err", i), {31'd0, err0}, 32'd0);
      if (i == 0) begin
        chk("seq step0", {24'd0, obsSeq[0]}, {24'd0, 4'd12, 4'd3});
        chk("seq step1", {24'd0, obsSeq[1]}, {24'd0, 4'd12, 4'd10});
        chk("seq step2", {24'd0, obsSeq[2]}, {24'd0, 4'd12, 4'd5});
        chk("seq step3", {24'd0, obsSeq[3]}, {24'd0, 4'd3, 4'd10});
        chk("seq step4", {24'd0, obsSeq[4]}, {24'd0, 4'd10, 4'd5});
        chk("seq step5", {24'd0, obsSeq[5]}, {24'd0, 4'd3, 4'd5});
      end
    end

    // Start pulsed while busy at step 2 must be ignored
    runSort(p4(15, 10, 5, 0), p4(0, 5, 10, 15), 3'd6, 2, -1, 1'b0, '0, "pulse");

    // Start held through DONE into IDLE: accepted only in IDLE
    runSort(p4(4, 3, 2, 1), p4(1, 2, 3, 4), 3'd6, -1, -1, 1'b1, p4(9, 2, 9, 1), "hold1");
    runSort(p4(9, 2, 9, 1), p4(1, 2, 9, 9), 3'd4, -1, -1, 1'b0, '0, "hold2");

    // Descending instance with gt=lt=1 injected at step 1
    runSort(p4(12, 3, 10, 5), p4(3, 5, 10, 12), 3'd4, -1, 1, 1'b0, '0, "fault");
    chk("desc dout",     {16'd0, dout1}, {16'd0, p4(12, 10, 5, 3)});
    chk("desc swaps",    {29'd0, swaps1}, 32'd2);
    chk("err before",    {31'd0, errSeq[1]}, 32'd0);
    chk("err after",     {31'd0, errSeq[2]}, 32'd1);
    chk("err asc clean", {31'd0, err0}, 32'd0);
    runSort(p4(0, 5, 10, 15), p4(0, 5, 10, 15), 3'd0, -1, -1, 1'b0, '0, "sticky");
    chk("err sticky",    {31'd0, err1}, 32'd1);

    // Reset during step 3 aborts with nothing kept and clears cmp_err
    start = 1'b1; din = p4(15, 10, 5, 0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort busy/done", {30'd0, busy0, done0}, 32'd0);
    chk("abort dout",      {16'd0, dout0}, 32'd0);
    chk("abort swaps",     {29'd0, swaps0}, 32'd0);
    chk("abort cmp_err",   {31'd0, err1}, 32'd0);
    rst_n = 1'b1;
    sawDone = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done0) sawDone = 1'b1;
    end
    chk("abort no done", {31'd0, sawDone}, 32'd0);
    runSort(p4(1, 0, 3, 2), p4(0, 1, 2, 3), 3'd2, -1, -1, 1'b0, '0, "recover");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
